// File: rtl/vc_test_rand_delay_mem_nport.sv
// N-port test memory: each port adds an LFSR-driven random latency, then all ports
// share one byte-addressed array through a round-robin arbiter (read/write/init/AMO).
module vc_test_rand_delay_mem_nport #(
  parameter int unsigned p_num_ports    = 2,
  parameter int unsigned p_mem_nbytes   = 1 << 16,
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_addr_nbits   = 32,
  parameter int unsigned p_data_nbits   = 128,
  parameter logic [31:0] p_lfsr_seed    = 32'hace1,
  localparam int unsigned LenNbits      = $clog2(p_data_nbits / 8),
  localparam int unsigned ReqNbits      = 3 + p_opaque_nbits + p_addr_nbits + LenNbits
                                          + p_data_nbits,
  localparam int unsigned RespNbits     = 3 + p_opaque_nbits + LenNbits + p_data_nbits
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               mem_clear,
  input  logic [31:0]                        max_delay,
  input  logic [p_num_ports-1:0]             memreq_val,
  output logic [p_num_ports-1:0]             memreq_rdy,
  input  logic [p_num_ports*ReqNbits-1:0]    memreq_msg,
  output logic [p_num_ports-1:0]             memresp_val,
  input  logic [p_num_ports-1:0]             memresp_rdy,
  output logic [p_num_ports*RespNbits-1:0]   memresp_msg
);

  localparam int unsigned BytesPerWord = p_data_nbits / 8;
  localparam int unsigned MemAddrNbits = $clog2(p_mem_nbytes);
  localparam int unsigned IdxNbits     = MemAddrNbits - LenNbits;
  localparam int unsigned NumWords     = p_mem_nbytes / BytesPerWord;
  localparam int unsigned PortIdxNbits = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;

  localparam logic [2:0] TypeRd   = 3'd0;
  localparam logic [2:0] TypeWr   = 3'd1;
  localparam logic [2:0] TypeInit = 3'd2;
  localparam logic [2:0] TypeAdd  = 3'd3;
  localparam logic [2:0] TypeAnd  = 3'd4;
  localparam logic [2:0] TypeOr   = 3'd5;

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  typedef enum logic [1:0] {StIdle, StDelay, StWaitGnt, StResp} state_e;

  logic [p_num_ports-1:0]  wait_vec;
  logic [p_num_ports-1:0]  gnt;
  logic                    gnt_any;
  logic [PortIdxNbits-1:0] gnt_idx;
  logic [PortIdxNbits-1:0] ptr_q;
  logic [ReqNbits-1:0]     req_bus [p_num_ports];
  logic [RespNbits-1:0]    resp_msg;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first pass from ptr upward, second pass wraps around.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!mem_clear) begin
      for (int unsigned p = 0; p < p_num_ports; p++) begin
        if (!gnt_any && wait_vec[p] && (PortIdxNbits'(p) >= ptr_q)) begin
          gnt_any = 1'b1;
          gnt_idx = PortIdxNbits'(p);
        end
      end
      for (int unsigned p = 0; p < p_num_ports; p++) begin
        if (!gnt_any && wait_vec[p]) begin
          gnt_any = 1'b1;
          gnt_idx = PortIdxNbits'(p);
        end
      end
    end
    gnt = gnt_any ? (p_num_ports'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == PortIdxNbits'(p_num_ports - 1)) ? '0 : gnt_idx + PortIdxNbits'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Array access for the granted port
  // ---------------------------------------------------------------------------
  logic [p_data_nbits-1:0]   mem [NumWords];
  logic [ReqNbits-1:0]       acc_req;
  logic [2:0]                acc_type;
  logic [p_opaque_nbits-1:0] acc_opq;
  logic [p_addr_nbits-1:0]   acc_addr;
  logic [LenNbits-1:0]       acc_len;
  logic [p_data_nbits-1:0]   acc_data;
  logic [IdxNbits-1:0]       acc_idx;
  logic [LenNbits-1:0]       acc_off;
  logic [LenNbits:0]         nb;
  logic [LenNbits+2:0]       sh;
  logic [p_data_nbits-1:0]   byte_mask;
  logic [p_data_nbits-1:0]   old_word;
  logic [p_data_nbits-1:0]   old_val;
  logic [p_data_nbits-1:0]   new_val;
  logic [p_data_nbits-1:0]   new_word;
  logic [p_data_nbits-1:0]   resp_data;
  logic                      do_write;
  logic                      unused_addr;

  assign acc_req  = req_bus[gnt_idx];
  assign acc_type = acc_req[ReqNbits-1 -: 3];
  assign acc_opq  = acc_req[ReqNbits-4 -: p_opaque_nbits];
  assign acc_addr = acc_req[p_data_nbits+LenNbits +: p_addr_nbits];
  assign acc_len  = acc_req[p_data_nbits +: LenNbits];
  assign acc_data = acc_req[0 +: p_data_nbits];
  assign acc_idx  = acc_addr[MemAddrNbits-1:LenNbits];
  assign acc_off  = acc_addr[LenNbits-1:0];
  // Address bits above the array size wrap back onto the array.
  assign unused_addr = ^acc_addr[p_addr_nbits-1:MemAddrNbits];

  always_comb begin
    nb        = (acc_len == '0) ? (LenNbits+1)'(BytesPerWord) : {1'b0, acc_len};
    sh        = {acc_off, 3'b000};
    byte_mask = '0;
    for (int unsigned j = 0; j < BytesPerWord; j++) begin
      byte_mask[j*8 +: 8] = ((LenNbits+1)'(j) < nb) ? 8'hff : 8'h00;
    end
    old_word  = mem[acc_idx];
    old_val   = (old_word >> sh) & byte_mask;
    new_val   = old_val;
    do_write  = 1'b1;
    resp_data = old_val;
    unique case (acc_type)
      TypeWr, TypeInit: begin
        new_val   = acc_data & byte_mask;
        resp_data = '0;
      end
      TypeAdd: new_val = (old_val + acc_data) & byte_mask;
      TypeAnd: new_val = old_val & acc_data;
      TypeOr:  new_val = (old_val | acc_data) & byte_mask;
      default: do_write = 1'b0;
    endcase
    // Bytes shifted past the top of the word fall off and are not written.
    new_word = (old_word & ~(byte_mask << sh)) | (new_val << sh);
    resp_msg = {acc_type, acc_opq, acc_len, resp_data};
  end

  always_ff @(posedge clk) begin
    if (mem_clear) begin
      for (int unsigned w = 0; w < NumWords; w++) begin
        mem[w] <= '0;
      end
    end else if (gnt_any && do_write) begin
      mem[acc_idx] <= new_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port delay FSMs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < p_num_ports; i++) begin : g_port
    state_e                state_q;
    logic [31:0]           cnt_q;
    logic [31:0]           lfsr_q;
    logic [31:0]           lfsr_next;
    logic [32:0]           delay;
    logic [ReqNbits-1:0]   req_q;
    logic [RespNbits-1:0]  resp_q;
    logic                  unused_delay_msb;

    assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
    // 33-bit math keeps max_delay = 2^32-1 from overflowing the modulus.
    assign delay            = {1'b0, lfsr_q} % ({1'b0, max_delay} + 33'd1);
    assign unused_delay_msb = delay[32];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        lfsr_q  <= p_lfsr_seed ^ 32'(i);
        req_q   <= '0;
        resp_q  <= '0;
      end else begin
        lfsr_q <= lfsr_next;
        unique case (state_q)
          StIdle: begin
            if (memreq_val[i]) begin
              req_q <= memreq_msg[i*ReqNbits +: ReqNbits];
              if (delay == '0) begin
                state_q <= StWaitGnt;
              end else begin
                state_q <= StDelay;
                cnt_q   <= delay[31:0];
              end
            end
          end
          StDelay: begin
            cnt_q <= cnt_q - 32'd1;
            if (cnt_q == 32'd1) state_q <= StWaitGnt;
          end
          StWaitGnt: begin
            if (gnt[i]) begin
              resp_q  <= resp_msg;
              state_q <= StResp;
            end
          end
          StResp: begin
            if (memresp_rdy[i]) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign wait_vec[i]                            = (state_q == StWaitGnt);
    assign req_bus[i]                             = req_q;
    assign memreq_rdy[i]                          = reset && (state_q == StIdle);
    assign memresp_val[i]                         = (state_q == StResp);
    assign memresp_msg[i*RespNbits +: RespNbits]  = resp_q;
  end

endmodule
